// File: rtl/oci_dct_pkg.sv
// rtl/oci_dct_pkg.sv - shared constants, frame layout and state encoding for the DCT packer
package oci_dct_pkg;

    localparam int ATOM_W    = 2;               // bits per trace atom
    localparam int SLOTS     = 15;              // atoms per frame
    localparam int BUF_W     = SLOTS * ATOM_W;  // packing buffer width (30)
    localparam int COUNT_LSB = BUF_W;           // fill count sits above the buffer
    localparam int COUNT_W   = 4;
    localparam int FRAME_W   = COUNT_LSB + COUNT_W;

    // Frame as written to trace RAM: {count[3:0], buffer[29:0]}
    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic [BUF_W-1:0]   buffer;
    } frame_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/nios_fprint_cpu_oci_dct_packer_if.sv
// rtl/nios_fprint_cpu_oci_dct_packer_if.sv - trace-write valid/ready port between packer and trace RAM
// Signals: tw_valid (frame offered), tw_data (frame_t), tw_addr (RAM word address), tw_ready (RAM takes frame).
// master = packer side, slave = trace RAM side.
interface nios_fprint_cpu_oci_dct_packer_if
    import oci_dct_pkg::*;
#(
    parameter int TRACE_AW = 7
) ();
    logic                tw_valid;
    frame_t              tw_data;
    logic [TRACE_AW-1:0] tw_addr;
    logic                tw_ready;

    modport master (output tw_valid, output tw_data, output tw_addr, input tw_ready);
    modport slave  (input tw_valid, input tw_data, input tw_addr, output tw_ready);
endinterface

// File: rtl/oci_dct_outreg.sv
// rtl/oci_dct_outreg.sv - single-entry valid/ready holding register with wrapping trace address
// Ports: clk, reset_n (sync, active-low); load/frame_in from the packer; ready from trace RAM;
// valid/data/addr toward trace RAM; wrap (sticky); free (entry can take a frame this edge).
module oci_dct_outreg
    import oci_dct_pkg::*;
#(
    parameter int TRACE_AW = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  frame_t              frame_in,
    input  logic                ready,
    output logic                valid,
    output frame_t              data,
    output logic [TRACE_AW-1:0] addr,
    output logic                wrap,
    output logic                free
);

    // Entry may be reloaded on the same edge that hands the current frame off.
    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
            wrap  <= 1'b0;
        end else begin
            if (valid && ready) begin
                addr <= addr + 1'b1;
                if (&addr)
                    wrap <= 1'b1;
            end
            if (load) begin
                valid <= 1'b1;
                data  <= frame_in;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nios_fprint_cpu_oci_dct_packer.sv
// rtl/nios_fprint_cpu_oci_dct_packer.sv - packs 2-bit trace atoms into 30-bit frames and drains them to trace RAM
// Ports: clk, reset_n (sync, active-low); trc_on, atom_valid, atom, flush_req, end_req in;
// dct_buffer, dct_count (packing state); tw (master trace-write port); trc_wrap, trc_ovf,
// test_ending, test_has_ended status out.
module nios_fprint_cpu_oci_dct_packer
    import oci_dct_pkg::*;
#(
    parameter int TRACE_AW = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trc_on,
    input  logic                     atom_valid,
    input  logic [ATOM_W-1:0]        atom,
    input  logic                     flush_req,
    input  logic                     end_req,
    output logic [BUF_W-1:0]         dct_buffer,
    output logic [COUNT_W-1:0]       dct_count,
    nios_fprint_cpu_oci_dct_packer_if.master tw,
    output logic                     trc_wrap,
    output logic                     trc_ovf,
    output logic                     test_ending,
    output logic                     test_has_ended
);

    state_e              state;
    logic                flush_pending;
    logic                accept, flush_in, flush_eff, free, load, drop;
    logic [COUNT_W-1:0]  nxt_cnt;
    logic [BUF_W-1:0]    nxt_buf;
    frame_t              ld_frame;
    logic                or_valid;
    frame_t              or_data;
    logic [TRACE_AW-1:0] or_addr;

    assign accept    = atom_valid && trc_on && (state == COLLECT);
    assign flush_in  = flush_pending || (flush_req && (state == COLLECT));
    // Draining behaves like a flush held high until the buffer is empty.
    assign flush_eff = flush_in || (state == DRAIN);

    always_comb begin
        load     = 1'b0;
        drop     = 1'b0;
        ld_frame = '0;
        nxt_cnt  = dct_count;
        nxt_buf  = dct_buffer;
        if (accept && dct_count == COUNT_W'(SLOTS)) begin
            // Full buffer: the new atom either starts the next frame or is lost.
            if (free) begin
                load     = 1'b1;
                ld_frame = '{count: dct_count, buffer: dct_buffer};
                nxt_buf  = BUF_W'(atom);
                nxt_cnt  = COUNT_W'(1);
            end else begin
                drop = 1'b1;
            end
        end else begin
            if (accept) begin
                nxt_buf = dct_buffer | (BUF_W'(atom) << (ATOM_W * int'(dct_count)));
                nxt_cnt = dct_count + 1'b1;
            end
            if (free && (nxt_cnt == COUNT_W'(SLOTS) || (flush_eff && nxt_cnt != '0))) begin
                load     = 1'b1;
                ld_frame = '{count: nxt_cnt, buffer: nxt_buf};
                nxt_buf  = '0;
                nxt_cnt  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= COLLECT;
            dct_buffer     <= '0;
            dct_count      <= '0;
            flush_pending  <= 1'b0;
            trc_ovf        <= 1'b0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            dct_buffer    <= nxt_buf;
            dct_count     <= nxt_cnt;
            // A flush of an empty buffer has nothing to wait for.
            flush_pending <= flush_in && !load && (nxt_cnt != '0);
            if (drop)
                trc_ovf <= 1'b1;
            case (state)
                COLLECT: if (end_req) begin
                    state       <= DRAIN;
                    test_ending <= 1'b1;
                end
                DRAIN: if (dct_count == '0 && !flush_pending && !or_valid) begin
                    state          <= DONE;
                    test_ending    <= 1'b0;
                    test_has_ended <= 1'b1;
                end
                default: state <= DONE;
            endcase
        end
    end

    oci_dct_outreg #(.TRACE_AW(TRACE_AW)) u_outreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .frame_in (ld_frame),
        .ready    (tw.tw_ready),
        .valid    (or_valid),
        .data     (or_data),
        .addr     (or_addr),
        .wrap     (trc_wrap),
        .free     (free)
    );

    assign tw.tw_valid = or_valid;
    assign tw.tw_data  = or_data;
    assign tw.tw_addr  = or_addr;

endmodule

// File: tb/tb_nios_fprint_cpu_oci_dct_packer.sv
// tb/tb_nios_fprint_cpu_oci_dct_packer.sv - self-checking bench for the DCT packer
module tb_nios_fprint_cpu_oci_dct_packer;
    import oci_dct_pkg::*;

    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trc_on = 1'b0, atom_valid = 1'b0, flush_req = 1'b0, end_req = 1'b0;
    logic [1:0]  atom = 2'd0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        trc_wrap, trc_ovf, test_ending, test_has_ended;

    nios_fprint_cpu_oci_dct_packer_if #(.TRACE_AW(AW)) tw_if ();

    nios_fprint_cpu_oci_dct_packer #(.TRACE_AW(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trc_on         (trc_on),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .flush_req      (flush_req),
        .end_req        (end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .tw             (tw_if),
        .trc_wrap       (trc_wrap),
        .trc_ovf        (trc_ovf),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: atoms held as a plain list, frame entry as a flag + value.
    int          m_q[$];
    bit          m_ov;
    logic [33:0] m_data;
    int          m_addr;
    bit          m_wrap, m_ovf, m_pend;
    int          m_st;   // 0 collecting, 1 draining, 2 done

    function automatic logic [29:0] m_buf();
        logic [29:0] b = '0;
        foreach (m_q[k]) b = b | (30'(m_q[k]) << (2 * k));
        return b;
    endfunction

    task automatic m_emit();
        m_data = {4'(m_q.size()), m_buf()};
        m_ov   = 1'b1;
    endtask

    task automatic m_step();
        bit free, acc, loaded, collect, fl_in, old_ov, old_pend;
        int old_sz;
        if (!reset_n) begin
            m_q.delete();
            m_ov = 0; m_data = '0; m_addr = 0; m_wrap = 0; m_ovf = 0; m_pend = 0; m_st = 0;
        end else begin
            old_sz   = m_q.size();
            old_ov   = m_ov;
            old_pend = m_pend;
            collect  = (m_st == 0);
            free     = !m_ov || tw_if.tw_ready;
            if (m_ov && tw_if.tw_ready) begin
                if (m_addr == (1 << AW) - 1) m_wrap = 1;
                m_addr = (m_addr + 1) % (1 << AW);
                m_ov   = 0;
            end
            acc    = atom_valid && trc_on && collect;
            fl_in  = m_pend || (flush_req && collect);
            loaded = 0;
            if (acc && old_sz == 15) begin
                if (free) begin
                    m_emit();
                    m_q.delete();
                    m_q.push_back(int'(atom));
                    loaded = 1;
                end else begin
                    m_ovf = 1;
                end
            end else begin
                if (acc) m_q.push_back(int'(atom));
                if (free && (m_q.size() == 15 || ((fl_in || m_st == 1) && m_q.size() > 0))) begin
                    m_emit();
                    m_q.delete();
                    loaded = 1;
                end
            end
            m_pend = fl_in && !loaded && (m_q.size() > 0);
            if (m_st == 0 && end_req) m_st = 1;
            else if (m_st == 1 && old_sz == 0 && !old_pend && !old_ov) m_st = 2;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("tw_valid", 64'(tw_if.tw_valid), 64'(m_ov));
        if (m_ov) begin
            chk("tw_data", 64'(tw_if.tw_data), 64'(m_data));
            chk("tw_addr", 64'(tw_if.tw_addr), 64'(m_addr));
        end
        chk("dct_count", 64'(dct_count), 64'(m_q.size()));
        chk("dct_buffer", 64'(dct_buffer), 64'(m_buf()));
        chk("trc_wrap", 64'(trc_wrap), 64'(m_wrap));
        chk("trc_ovf", 64'(trc_ovf), 64'(m_ovf));
        chk("test_ending", 64'(test_ending), 64'(m_st == 1));
        chk("test_has_ended", 64'(test_has_ended), 64'(m_st == 2));
    endtask

    task automatic cyc(input bit av, input logic [1:0] a, input bit trc, input bit fl,
                       input bit en, input bit rdy);
        atom_valid = av; atom = a; trc_on = trc; flush_req = fl; end_req = en;
        tw_if.tw_ready = rdy;
        @(posedge clk);
        m_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        bit done;
        tw_if.tw_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_count", 64'(dct_count), 64'd0);
        chk("rst_valid", 64'(tw_if.tw_valid), 64'd0);

        // Full frame: atoms 0,1,2,3,0,... with ready high
        for (int i = 0; i < 15; i++) cyc(1, 2'(i % 4), 1, 0, 0, 1);
        chk("full_valid", 64'(tw_if.tw_valid), 64'd1);
        chk("full_data", 64'(tw_if.tw_data), {30'd0, 4'hF, 30'h24E4E4E4});
        chk("full_addr", 64'(tw_if.tw_addr), 64'd0);
        chk("full_count", 64'(dct_count), 64'd0);
        cyc(0, 0, 1, 0, 0, 1);

        // Partial flush, then a flush of an empty buffer
        cyc(1, 2'd3, 1, 0, 0, 1);
        cyc(1, 2'd3, 1, 0, 0, 1);
        cyc(1, 2'd1, 1, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 1);
        chk("flush_data", 64'(tw_if.tw_data), {30'd0, 4'h3, 30'h0000001F});
        chk("flush_addr", 64'(tw_if.tw_addr), 64'd1);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 1, 0, 1);
        chk("empty_flush", 64'(tw_if.tw_valid), 64'd0);

        // Back-pressure: 32 atoms with ready low
        for (int i = 0; i < 32; i++) cyc(1, 2'($urandom_range(0, 3)), 1, 0, 0, 0);
        chk("bp_valid", 64'(tw_if.tw_valid), 64'd1);
        chk("bp_count", 64'(dct_count), 64'd15);
        chk("bp_ovf", 64'(trc_ovf), 64'd1);

        // Atom arrives as the full buffer transfers
        cyc(1, 2'd2, 1, 0, 0, 1);
        chk("sim_count", 64'(dct_count), 64'd1);
        chk("sim_slot0", 64'(dct_buffer[1:0]), 64'd2);
        chk("sim_addr", 64'(tw_if.tw_addr), 64'd3);

        // Fourth acceptance (address 3 -> 0) wraps
        cyc(0, 0, 1, 0, 0, 1);
        chk("wrap", 64'(trc_wrap), 64'd1);

        // Randomized traffic with occasional resets and end requests
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            cyc($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom_range(0, 19) != 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 9) < 6);
        end
        reset_n = 1'b1;

        // End of test with 7 atoms buffered and a stalled trace RAM
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1, 2'(i % 4), 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 1, 0);
        chk("end_ending", 64'(test_ending), 64'd1);
        for (int i = 0; i < 4; i++) cyc(1, 2'd1, 1, 0, 0, 0);
        chk("end_frame_cnt", 64'(tw_if.tw_data[33:30]), 64'h7);
        chk("end_count", 64'(dct_count), 64'd0);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(1, 2'd1, 1, 0, 0, 1);
            done = test_has_ended;
        end
        chk("end_has_ended", 64'(test_has_ended), 64'd1);
        chk("end_not_ending", 64'(test_ending), 64'd0);
        cyc(1, 2'd3, 1, 1, 1, 1);
        cyc(1, 2'd3, 1, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
